// File: rtl/prbs_chk.sv
// PRBS31 receive checker: hunts for the sequence, verifies it, then counts bit
// errors against a free-running local LFSR and drops lock on bursts of errored bytes.
module prbs_chk #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_WIN = 32,
    parameter int LOSS_THR = 8
) (
    input  logic        clk_in,
    input  logic        arst_in,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    input  logic        clr_in,
    output logic        lock_out,
    output logic        err_out,
    output logic [31:0] err_cnt_out,
    output logic [47:0] bit_cnt_out,
    output logic [1:0]  state_out
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    localparam int EW = $clog2(LOSS_THR + 1);
    localparam logic [47:0] BIT_SAT_THR = 48'hFFFF_FFFF_FFF7;

    logic [1:0]    r_state;
    logic [30:0]   r_hist;
    logic [30:0]   r_lfsr;
    logic [1:0]    r_fill;
    logic [GW-1:0] r_good;
    logic [WW-1:0] r_win;
    logic [EW-1:0] r_ebytes;
    logic [31:0]   r_err_cnt;
    logic [47:0]   r_bit_cnt;
    logic          r_err;

    logic [30:0]   w_src;
    logic [30:0]   w_chain [0:8];
    logic [7:0]    w_pred;
    logic [7:0]    w_diff;
    logic [3:0]    w_pop;
    logic          w_byte_err;
    logic [30:0]   w_hist_rx;
    logic [EW-1:0] w_ebytes_next;
    logic [32:0]   w_err_sum;

    // One shared 8-step predictor: hist drives it while acquiring, the LFSR once locked.
    assign w_src      = (r_state == ST_LOCKED) ? r_lfsr : r_hist;
    assign w_chain[0] = w_src;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_step
            logic w_bit;
            assign w_bit          = w_chain[gi][30] ^ w_chain[gi][27];
            assign w_chain[gi+1]  = {w_chain[gi][29:0], w_bit};
            assign w_pred[7-gi]   = w_bit;
        end
    endgenerate

    assign w_diff     = data_in ^ w_pred;
    assign w_byte_err = (w_pop != 4'd0);
    assign w_hist_rx  = {r_hist[22:0], data_in};

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'd0, w_diff[i]};
        end
    end

    // The errored-byte tally restarts on the first byte of every window.
    assign w_ebytes_next = ((r_win == '0) ? '0 : r_ebytes) + EW'(w_byte_err);
    assign w_err_sum     = {1'b0, r_err_cnt} + {29'd0, w_pop};

    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            r_state  <= ST_HUNT;
            r_hist   <= '0;
            r_lfsr   <= '0;
            r_fill   <= '0;
            r_good   <= '0;
            r_win    <= '0;
            r_ebytes <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (valid_in) begin
                case (r_state)
                    ST_HUNT: begin
                        r_hist <= w_hist_rx;
                        if (r_fill == 2'd3) begin
                            r_fill  <= '0;
                            r_state <= ST_VERIFY;
                        end else begin
                            r_fill <= r_fill + 2'd1;
                        end
                    end
                    ST_VERIFY: begin
                        r_hist <= w_hist_rx;
                        if (r_hist == '0 || w_byte_err) begin
                            r_good <= '0;
                        end else if (r_good == GW'(LOCK_CNT - 1)) begin
                            r_good   <= '0;
                            r_state  <= ST_LOCKED;
                            r_lfsr   <= w_hist_rx;
                            r_win    <= '0;
                            r_ebytes <= '0;
                        end else begin
                            r_good <= r_good + GW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        r_lfsr   <= w_chain[8];
                        r_err    <= w_byte_err;
                        r_win    <= (r_win == WW'(LOSS_WIN - 1)) ? '0 : r_win + WW'(1);
                        r_ebytes <= w_ebytes_next;
                        if (w_ebytes_next == EW'(LOSS_THR)) begin
                            r_state  <= ST_HUNT;
                            r_hist   <= '0;
                            r_fill   <= '0;
                            r_good   <= '0;
                            r_win    <= '0;
                            r_ebytes <= '0;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge arst_in) begin
        if (arst_in) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (clr_in) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
        end else if (valid_in && r_state == ST_LOCKED) begin
            r_err_cnt <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
            r_bit_cnt <= (r_bit_cnt > BIT_SAT_THR) ? 48'hFFFF_FFFF_FFFF : r_bit_cnt + 48'd8;
        end
    end

    // LOCKED is the only encoding with bit 1 set, so lock comes straight off a flop.
    assign lock_out    = r_state[1];
    assign state_out   = r_state;
    assign err_out     = r_err;
    assign err_cnt_out = r_err_cnt;
    assign bit_cnt_out = r_bit_cnt;

endmodule

// File: tb/tb_prbs_chk.sv
// Directed bench for prbs_chk: acquisition, single and burst errors, loss/relock,
// counter clear, asynchronous reset and an all-zero stream.
module tb_prbs_chk;

    logic        clk_in;
    logic        arst_in;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        clr_in;
    logic        lock_out;
    logic        err_out;
    logic [31:0] err_cnt_out;
    logic [47:0] bit_cnt_out;
    logic [1:0]  state_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [30:0] g_st;
    logic [7:0]  b;
    logic        saw_bad;

    prbs_chk dut (
        .clk_in      (clk_in),
        .arst_in     (arst_in),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .clr_in      (clr_in),
        .lock_out    (lock_out),
        .err_out     (err_out),
        .err_cnt_out (err_cnt_out),
        .bit_cnt_out (bit_cnt_out),
        .state_out   (state_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference prbs_gen: emits state[30] first, s[n] = s[n-31] ^ s[n-28].
    task automatic gen(output logic [7:0] ob);
        for (int i = 0; i < 8; i++) begin
            ob[7-i] = g_st[30];
            g_st    = {g_st[29:0], g_st[30] ^ g_st[27]};
        end
    endtask

    task automatic send(input logic [7:0] d, input logic clr);
        valid_in = 1'b1;
        data_in  = d;
        clr_in   = clr;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        clr_in   = 1'b0;
    endtask

    task automatic idle(input logic [7:0] junk);
        valid_in = 1'b0;
        data_in  = junk;
        @(posedge clk_in);
        #1;
    endtask

    task automatic clean();
        logic [7:0] cb;
        gen(cb);
        send(cb, 1'b0);
    endtask

    initial begin
        arst_in  = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        clr_in   = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_state", 64'(state_out), 64'd0);
        chk("rst_lock", 64'(lock_out), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_errcnt", 64'(err_cnt_out), 64'd0);
        chk("rst_bitcnt", 64'(bit_cnt_out), 64'd0);
        arst_in = 1'b0;

        // Acquisition with idle cycles carrying junk data in HUNT and VERIFY
        g_st = 31'h6F7B38ED;
        clean();                                   // byte 1
        chk("hunt_b1_state", 64'(state_out), 64'd0);
        clean();                                   // byte 2
        idle(8'hA5);
        clean();                                   // byte 3
        chk("hunt_b3_state", 64'(state_out), 64'd0);
        clean();                                   // byte 4
        chk("verify_b4_state", 64'(state_out), 64'd1);
        clean();                                   // byte 5
        idle(8'h3C);
        clean();                                   // byte 6
        clean();                                   // byte 7
        chk("b7_lock", 64'(lock_out), 64'd0);
        chk("b7_state", 64'(state_out), 64'd1);
        clean();                                   // byte 8
        chk("b8_lock", 64'(lock_out), 64'd1);
        chk("b8_state", 64'(state_out), 64'd2);
        chk("b8_bitcnt", 64'(bit_cnt_out), 64'd0);
        clean();                                   // byte 9, first counted
        chk("b9_bitcnt", 64'(bit_cnt_out), 64'd8);
        chk("b9_errout", 64'(err_out), 64'd0);
        for (int k = 10; k <= 100; k++) begin
            clean();
            if (k % 17 == 0) idle(8'hFF);
        end
        chk("b100_errcnt", 64'(err_cnt_out), 64'd0);
        chk("b100_bitcnt", 64'(bit_cnt_out), 64'd736);
        chk("b100_lock", 64'(lock_out), 64'd1);

        // Single bit error on data_in[3] (byte 101, window slot 28)
        gen(b);
        send(b ^ 8'h08, 1'b0);
        chk("b101_errout", 64'(err_out), 64'd1);
        chk("b101_errcnt", 64'(err_cnt_out), 64'd1);
        chk("b101_lock", 64'(lock_out), 64'd1);
        clean();                                   // byte 102
        chk("b102_errout", 64'(err_out), 64'd0);
        chk("b102_bitcnt", 64'(bit_cnt_out), 64'd752);
        clean();
        clean();                                   // byte 104 ends the window

        // Burst of 8 fully inverted bytes starting at a window boundary
        for (int k = 105; k <= 112; k++) begin
            gen(b);
            send(b ^ 8'hFF, 1'b0);
            if (k == 111) begin
                chk("b111_errcnt", 64'(err_cnt_out), 64'd57);
                chk("b111_lock", 64'(lock_out), 64'd1);
            end
        end
        chk("b112_lock", 64'(lock_out), 64'd0);
        chk("b112_state", 64'(state_out), 64'd0);
        chk("b112_errout", 64'(err_out), 64'd1);
        chk("b112_errcnt", 64'(err_cnt_out), 64'd65);
        chk("b112_bitcnt", 64'(bit_cnt_out), 64'd832);

        // Relock on the clean stream
        for (int k = 113; k <= 119; k++) begin
            clean();
            if (k == 113) chk("b113_errout", 64'(err_out), 64'd0);
            if (k == 116) chk("b116_state", 64'(state_out), 64'd1);
        end
        chk("b119_lock", 64'(lock_out), 64'd0);
        clean();                                   // byte 120
        chk("b120_lock", 64'(lock_out), 64'd1);
        chk("b120_errcnt", 64'(err_cnt_out), 64'd65);
        chk("b120_bitcnt", 64'(bit_cnt_out), 64'd832);
        clean();                                   // byte 121
        chk("b121_bitcnt", 64'(bit_cnt_out), 64'd840);

        // Clear coinciding with an errored counted byte: clear wins
        gen(b);
        send(b ^ 8'h01, 1'b1);
        chk("clr_errcnt", 64'(err_cnt_out), 64'd0);
        chk("clr_bitcnt", 64'(bit_cnt_out), 64'd0);
        chk("clr_lock", 64'(lock_out), 64'd1);
        clean();
        chk("postclr_bitcnt", 64'(bit_cnt_out), 64'd8);
        chk("postclr_errcnt", 64'(err_cnt_out), 64'd0);
        gen(b);
        send(b ^ 8'h30, 1'b0);
        chk("pre_arst_errcnt", 64'(err_cnt_out), 64'd2);
        chk("pre_arst_errout", 64'(err_out), 64'd1);
        chk("pre_arst_bitcnt", 64'(bit_cnt_out), 64'd16);

        // Asynchronous reset between clock edges
        #2;
        arst_in = 1'b1;
        #1;
        chk("arst_lock", 64'(lock_out), 64'd0);
        chk("arst_errout", 64'(err_out), 64'd0);
        chk("arst_errcnt", 64'(err_cnt_out), 64'd0);
        chk("arst_bitcnt", 64'(bit_cnt_out), 64'd0);
        chk("arst_state", 64'(state_out), 64'd0);
        @(posedge clk_in);
        #3;
        arst_in = 1'b0;

        // All-zero stream must never lock
        saw_bad = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            send(8'h00, 1'b0);
            if (lock_out || state_out == 2'd2) saw_bad = 1'b1;
            if (k == 4) chk("zero_b4_state", 64'(state_out), 64'd1);
        end
        chk("zero_never_locked", 64'(saw_bad), 64'd0);
        chk("zero_state", 64'(state_out), 64'd1);
        chk("zero_lock", 64'(lock_out), 64'd0);
        chk("zero_errcnt", 64'(err_cnt_out), 64'd0);
        chk("zero_bitcnt", 64'(bit_cnt_out), 64'd0);

        // Short reset pulse, then the first valid byte is the first HUNT byte
        #2;
        arst_in = 1'b1;
        #2;
        arst_in = 1'b0;
        chk("pulse_state", 64'(state_out), 64'd0);
        g_st = 31'h12345678;
        for (int k = 1; k <= 7; k++) clean();
        chk("s2_b7_lock", 64'(lock_out), 64'd0);
        chk("s2_b7_state", 64'(state_out), 64'd1);
        clean();
        chk("s2_b8_lock", 64'(lock_out), 64'd1);
        chk("s2_b8_state", 64'(state_out), 64'd2);
        gen(b);
        send(b ^ 8'h80, 1'b0);
        chk("s2_b9_errcnt", 64'(err_cnt_out), 64'd1);
        chk("s2_b9_bitcnt", 64'(bit_cnt_out), 64'd8);
        chk("s2_b9_errout", 64'(err_out), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
